// File: rtl/controle_batalha.sv
// controle_batalha: best-of-N match sequencer for the 3-bit move battle game.
// Collects one move per player per round over valid/ready, judges the round,
// keeps the score and declares a champion at the win target or round limit.
// Optional feature: define CB_TIMEOUT_EN to enable the per-round move timeout.
module controle_batalha #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 7,
  parameter int SCORE_W    = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         p1_move,
  input  logic               p1_valid,
  output logic               p1_ready,
  input  logic [2:0]         p2_move,
  input  logic               p2_valid,
  output logic               p2_ready,
  output logic               round_done,
  output logic [1:0]         round_winner,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [7:0]         round_cnt,
  output logic               busy,
  output logic               game_over,
  output logic [1:0]         champion
);

  // Reject parameter combinations the counters cannot represent.
  if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W) - 1 ||
      MAX_ROUNDS < 1 || MAX_ROUNDS > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("controle_batalha: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, JUDGE, OVER} state_t;

  state_t             state_q, state_d;
  logic [2:0]         m1_q, m1_d, m2_q, m2_d;
  logic               got1_q, got1_d, got2_q, got2_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [7:0]         round_cnt_q, round_cnt_d;
  logic [1:0]         winner_q, winner_d, champion_q, champion_d;
  logic               done_q, done_d;
  logic               acc1, acc2;
  logic [1:0]         verdict;

`ifdef CB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;
`endif

  // Move that player 2 must answer with to beat player 1's move.
  function automatic logic [2:0] counter_move(input logic [2:0] m);
    case (m)
      3'd0:    counter_move = 3'd5;
      3'd1:    counter_move = 3'd4;
      3'd2:    counter_move = 3'd2;
      3'd3:    counter_move = 3'd1;
      3'd4:    counter_move = 3'd7;
      3'd5:    counter_move = 3'd6;
      3'd6:    counter_move = 3'd3;
      default: counter_move = 3'd0;
    endcase
  endfunction

  // Battle rules: a uniform p1 move wins outright, else p2 wins on the counter.
  function automatic logic [1:0] judge_round(input logic [2:0] m1, input logic [2:0] m2);
    if (m1 == 3'd0 || m1 == 3'd7)
      judge_round = 2'b01;
    else if (m2 == counter_move(m1))
      judge_round = 2'b10;
    else
      judge_round = 2'b00;
  endfunction

  // Next-state, move capture and round scoring.
  always_comb begin
    state_d     = state_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    got1_d      = got1_q;
    got2_d      = got2_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    round_cnt_d = round_cnt_q;
    winner_d    = winner_q;
    champion_d  = champion_q;
    done_d      = 1'b0;
    acc1        = 1'b0;
    acc2        = 1'b0;
    verdict     = 2'b00;
`ifdef CB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    to_flag_d   = to_flag_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d     = COLLECT;
          score1_d    = '0;
          score2_d    = '0;
          round_cnt_d = '0;
          champion_d  = 2'b00;
          winner_d    = 2'b00;
`ifdef CB_TIMEOUT_EN
          to_cnt_d    = '0;
          to_flag_d   = 1'b0;
`endif
        end
      end
      COLLECT: begin
        acc1 = p1_valid & ~got1_q;
        acc2 = p2_valid & ~got2_q;
        if (acc1) begin
          m1_d   = p1_move;
          got1_d = 1'b1;
        end
        if (acc2) begin
          m2_d   = p2_move;
          got2_d = 1'b1;
        end
        if ((got1_q | acc1) & (got2_q | acc2)) begin
          state_d = JUDGE;
        end
`ifdef CB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = JUDGE;
          to_flag_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      JUDGE: begin
        verdict = judge_round(m1_q, m2_q);
`ifdef CB_TIMEOUT_EN
        // A timed-out round goes to whoever moved; nobody moved is a draw.
        if (to_flag_q) verdict = got1_q ? 2'b01 : (got2_q ? 2'b10 : 2'b00);
        to_cnt_d  = '0;
        to_flag_d = 1'b0;
`endif
        winner_d    = verdict;
        done_d      = 1'b1;
        got1_d      = 1'b0;
        got2_d      = 1'b0;
        round_cnt_d = round_cnt_q + 8'd1;
        if (verdict == 2'b01) score1_d = score1_q + 1'b1;
        if (verdict == 2'b10) score2_d = score2_q + 1'b1;
        if (score1_d == SCORE_W'(WIN_TARGET) || score2_d == SCORE_W'(WIN_TARGET) ||
            round_cnt_d == 8'(MAX_ROUNDS)) begin
          state_d = OVER;
          if (score1_d > score2_d)      champion_d = 2'b01;
          else if (score2_d > score1_d) champion_d = 2'b10;
          else                          champion_d = 2'b00;
        end else begin
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Match state and score registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m1_q        <= '0;
      m2_q        <= '0;
      got1_q      <= 1'b0;
      got2_q      <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      round_cnt_q <= '0;
      winner_q    <= 2'b00;
      champion_q  <= 2'b00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      got1_q      <= got1_d;
      got2_q      <= got2_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      round_cnt_q <= round_cnt_d;
      winner_q    <= winner_d;
      champion_q  <= champion_d;
      done_q      <= done_d;
    end
  end

`ifdef CB_TIMEOUT_EN
  // Per-round move timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end
`endif

  assign p1_ready     = (state_q == COLLECT) & ~got1_q;
  assign p2_ready     = (state_q == COLLECT) & ~got2_q;
  assign busy         = (state_q == COLLECT) | (state_q == JUDGE);
  assign game_over    = (state_q == OVER);
  assign round_done   = done_q;
  assign round_winner = winner_q;
  assign score1       = score1_q;
  assign score2       = score2_q;
  assign round_cnt    = round_cnt_q;
  assign champion     = champion_q;

endmodule

// File: tb/tb_controle_batalha.sv
// Directed bench for controle_batalha with a round-level reference model.
module tb_controle_batalha;
  localparam int WT = 3;
  localparam int MR = 7;
  localparam int SW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst, start, p1_valid, p2_valid;
  logic [2:0]    p1_move, p2_move;
  logic          p1_ready, p2_ready, round_done, busy, game_over;
  logic [1:0]    round_winner, champion;
  logic [SW-1:0] score1, score2;
  logic [7:0]    round_cnt;

  logic          b_p1_ready, b_p2_ready, b_round_done, b_busy, b_game_over;
  logic [1:0]    b_round_winner, b_champion;
  logic [SW-1:0] b_score1, b_score2;
  logic [7:0]    b_round_cnt;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  controle_batalha #(.WIN_TARGET(WT), .MAX_ROUNDS(MR), .SCORE_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
    .round_done(round_done), .round_winner(round_winner),
    .score1(score1), .score2(score2), .round_cnt(round_cnt),
    .busy(busy), .game_over(game_over), .champion(champion));

  // Second instance with a two-round limit, checked with literal expectations.
  controle_batalha #(.WIN_TARGET(WT), .MAX_ROUNDS(2), .SCORE_W(SW), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(b_p1_ready),
    .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(b_p2_ready),
    .round_done(b_round_done), .round_winner(b_round_winner),
    .score1(b_score1), .score2(b_score2), .round_cnt(b_round_cnt),
    .busy(b_busy), .game_over(b_game_over), .champion(b_champion));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (round level) ----------------
  bit       collecting, judging, finished, have1, have2, timed_out, e_done;
  int       e_s1, e_s2, e_rc, wait_cnt;
  int       e_win, e_champ;
  int       mv1, mv2;
  int       beats [8] = '{5, 4, 2, 1, 7, 6, 3, 0};

  function automatic int rule_of(input int a, input int b);
    if (a == 0 || a == 7) return 1;
    if (b == beats[a])    return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      collecting = 0; judging = 0; finished = 0; have1 = 0; have2 = 0;
      timed_out = 0; e_done = 0; e_s1 = 0; e_s2 = 0; e_rc = 0; wait_cnt = 0;
      e_win = 0; e_champ = 0; mv1 = 0; mv2 = 0;
    end else begin
      e_done = 0;
      if (judging) begin
        e_win = timed_out ? (have1 ? 1 : (have2 ? 2 : 0)) : rule_of(mv1, mv2);
        e_done = 1;
        if (e_win == 1) e_s1++;
        if (e_win == 2) e_s2++;
        e_rc++;
        have1 = 0; have2 = 0; judging = 0; timed_out = 0; wait_cnt = 0;
        if (e_s1 == WT || e_s2 == WT || e_rc == MR) begin
          finished = 1;
          e_champ = (e_s1 > e_s2) ? 1 : ((e_s2 > e_s1) ? 2 : 0);
        end else begin
          collecting = 1;
        end
      end else if (collecting) begin
        if (p1_valid && !have1) begin have1 = 1; mv1 = int'(p1_move); end
        if (p2_valid && !have2) begin have2 = 1; mv2 = int'(p2_move); end
        wait_cnt++;
        if (have1 && have2) begin
          collecting = 0; judging = 1;
        end
`ifdef CB_TIMEOUT_EN
        else if (wait_cnt == TO) begin
          collecting = 0; judging = 1; timed_out = 1;
        end
`endif
      end else if (start) begin
        e_s1 = 0; e_s2 = 0; e_rc = 0; e_champ = 0; e_win = 0; wait_cnt = 0;
        finished = 0; collecting = 1;
      end
    end
  end

  // Compare every output against the model each cycle, away from the edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("p1_ready",     int'(p1_ready),     int'(collecting && !have1));
      check("p2_ready",     int'(p2_ready),     int'(collecting && !have2));
      check("busy",         int'(busy),         int'(collecting || judging));
      check("game_over",    int'(game_over),    int'(finished));
      check("round_done",   int'(round_done),   int'(e_done));
      check("round_winner", int'(round_winner), e_win);
      check("score1",       int'(score1),       e_s1);
      check("score2",       int'(score2),       e_s2);
      check("round_cnt",    int'(round_cnt),    e_rc);
      check("champion",     int'(champion),     e_champ);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(p1_ready && p2_ready) && n < 20) begin tick(); n++; end
    check("ready_seen", int'(p1_ready && p2_ready), 1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (round_done !== 1'b1 && n < limit) begin tick(); n++; end
    check("round_done_seen", int'(round_done), 1);
  endtask

  task automatic play_round(input logic [2:0] a, input logic [2:0] b);
    wait_ready();
    p1_move = a; p2_move = b; p1_valid = 1'b1; p2_valid = 1'b1;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    wait_done(20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    p1_move = 3'd0; p2_move = 3'd0;
    @(negedge clk);
    model_on = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_score1", int'(score1), 0);
    check("rst_ready1", int'(p1_ready), 0);
    rst = 1'b0;
    tick();

    // Same-cycle moves, p1 wins on a uniform move
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", int'(busy), 1);
    p1_move = 3'd0; p2_move = 3'd5; p1_valid = 1'b1; p2_valid = 1'b1;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("t1_judge_no_done", int'(round_done), 0);
    tick();
    check("t1_done", int'(round_done), 1);
    check("t1_winner", int'(round_winner), 1);
    check("t1_score1", int'(score1), 1);
    tick();
    check("t1_done_pulse", int'(round_done), 0);

    // p2 first, p1 three cycles later; p2 answers 1 with 4
    p2_move = 3'd4; p2_valid = 1'b1; tick(); p2_valid = 1'b0;
    check("t2_p2_ready", int'(p2_ready), 0);
    check("t2_p1_ready", int'(p1_ready), 1);
    tick(); tick();
    p1_move = 3'd1; p1_valid = 1'b1; tick(); p1_valid = 1'b0;
    tick();
    check("t2_winner", int'(round_winner), 2);
    check("t2_score2", int'(score2), 1);
    tick();

    // Draw; extra p1 valids with a winning move must be ignored
    p1_move = 3'd3; p1_valid = 1'b1; tick();
    p1_move = 3'd7; tick(); tick();
    check("t3_p1_ready", int'(p1_ready), 0);
    p2_move = 3'd2; p2_valid = 1'b1; tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    tick();
    check("t3_winner", int'(round_winner), 0);
    check("t3_score1", int'(score1), 1);
    check("t3_round_cnt", int'(round_cnt), 3);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("t3_start_busy_ignored", int'(round_cnt), 3);

    // Reach the win target
    play_round(3'd7, 3'd1);
    check("t4_score1_mid", int'(score1), 2);
    play_round(3'd7, 3'd1);
    check("t4_score1", int'(score1), 3);
    check("t4_game_over", int'(game_over), 1);
    check("t4_champion", int'(champion), 1);
    p1_move = 3'd0; p2_move = 3'd5; p1_valid = 1'b1; p2_valid = 1'b1;
    tick(); tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("t4_ignored_cnt", int'(round_cnt), 5);
    check("t4_hold_over", int'(game_over), 1);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_restart_score1", int'(score1), 0);
    check("t4_restart_busy", int'(busy), 1);

    // Reset mid-COLLECT, then round limit on the two-round instance
    p1_move = 3'd6; p1_valid = 1'b1; tick(); p1_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_ready1", int'(p1_ready), 0);
    check("t5_rst_champion", int'(champion), 0);
    check("t5_rst_b_busy", int'(b_busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    play_round(3'd3, 3'd2);
    play_round(3'd3, 3'd2);
    check("t5_b_game_over", int'(b_game_over), 1);
    check("t5_b_champion", int'(b_champion), 0);
    check("t5_b_round_cnt", int'(b_round_cnt), 2);
    check("t5_b_done", int'(b_round_done), 1);
    check("t5_a_game_over", int'(game_over), 0);

`ifdef CB_TIMEOUT_EN
    // Timeout: only p2 moves, then nobody moves
    p2_move = 3'd3; p2_valid = 1'b1; tick(); p2_valid = 1'b0;
    wait_done(40);
    check("t6_timeout_p2", int'(round_winner), 2);
    tick();
    wait_done(40);
    check("t6_timeout_draw", int'(round_winner), 0);
`else
    repeat (30) tick();
    check("t6_waits_busy", int'(busy), 1);
    check("t6_waits_cnt", int'(round_cnt), 2);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_batalha.md
Name: controle_batalha

Overview:
Sequences best-of-N matches of the 3-bit move battle game between two players.
- Collects one move per player per round over valid/ready handshakes.
- Judges each round with the fixed battle rules and keeps the score.
- Declares a champion when a player reaches the target or the round limit is hit.
- Sits between player input logic (switch debouncers/keypads) and the score display.

Parameters:
WIN_TARGET, 3, wins needed to end the match (1..2^SCORE_W-1)
MAX_ROUNDS, 7, round limit including draws (1..255)
SCORE_W, 3, width of each score counter
TIMEOUT, 15, per-round move timeout in cycles (used only with CB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin new match; honoured only in IDLE or OVER
p1_move  in  3  player 1 move {a,b,c}
p1_valid  in  1  player 1 move valid
p1_ready  out  1  controller can accept player 1 move
p2_move  in  3  player 2 move
p2_valid  in  1  player 2 move valid
p2_ready  out  1  controller can accept player 2 move
round_done  out  1  one-cycle pulse: round result valid
round_winner  out  2  00 draw, 01 p1, 10 p2, 11 unused
score1  out  SCORE_W  player 1 wins
score2  out  SCORE_W  player 2 wins
round_cnt  out  8  rounds played this match
busy  out  1  match in progress (COLLECT or JUDGE)
game_over  out  1  high in OVER
champion  out  2  00 tie, 01 p1, 10 p2; valid while game_over

Behaviour:
- Reset (sync, rst high at edge): state IDLE; all outputs 0; captured moves and flags cleared. Reset mid-match aborts the match with no result.
- States: IDLE, COLLECT, JUDGE, OVER.
- IDLE: start -> COLLECT; scores, round_cnt and champion cleared.
- OVER: start -> COLLECT with the same clearing; outputs hold until then.
- COLLECT:
  - p1_ready = ~got1 and p2_ready = ~got2; both ready signals are 0 outside COLLECT.
  - A move is accepted when valid & ready at an edge; it is latched and its got flag set.
  - Moves may arrive in either order or in the same cycle.
  - Once both flags are set (including same-edge acceptance), the next state is JUDGE.
- Move ignore rules: a player's valid while that player's got flag is set, or outside COLLECT, is ignored with no error.
- JUDGE (exactly one cycle), using latched moves m1, m2:
  - p1 wins if m1 bits are all equal (m1 = 0 or 7); this has priority.
  - Otherwise p2 wins if m2 == MAP(m1), with MAP: 0->5, 1->4, 2->2, 3->1, 4->7, 5->6, 6->3, 7->0.
  - Otherwise the round is a draw.
- JUDGE edge updates:
  - round_winner is registered and round_done pulses for the following cycle.
  - The winner's score increments; round_cnt increments.
  - got flags clear.
- JUDGE exit:
  - The next state is OVER if the new score equals WIN_TARGET or the new round_cnt equals MAX_ROUNDS.
  - Otherwise the next state is COLLECT.
  - Entering OVER registers champion from the higher score, 00 if equal.
  - game_over asserts in the same cycle as the final round_done.
- Latency: last accepting edge -> JUDGE -> round_done high 2 cycles after that edge's cycle began (1 cycle in JUDGE, pulse on the next).
- Scores never exceed WIN_TARGET; counters do not wrap.
- round_winner holds its value until the next JUDGE or start.
- busy = (state == COLLECT or JUDGE).
- start while busy is ignored.

Optional Feature:
Macro CB_TIMEOUT_EN.
- Defined: a cycle counter runs in COLLECT from round entry. If the count reaches TIMEOUT with exactly one move captured, the round is judged as a win for the captured player with no rules evaluation, via the normal JUDGE path. If neither move is captured, the round is a draw. The counter clears on JUDGE and on start.
- Undefined: no counter exists and COLLECT waits indefinitely. The TIMEOUT parameter is unused.

Test Plan:
1. Same-cycle moves, p1 priority: rst, start; p1=0, p2=5 in the same cycle -> round_winner=01, score1=1, round_done exactly one cycle, 2 cycles after acceptance.
2. Rule match, opposite order: p2=4 first, p1=1 three cycles later -> p2_ready drops after p2's acceptance, p1 still accepted; round_winner=10, score2=1.
3. Draw and ignore rule: p1=3, p2=2 -> round_winner=00, scores unchanged, round_cnt=1. Extra p1_valid pulses while got1 is set are ignored.
4. Match end by target: p1 plays 7 three rounds, p2 plays 1 each round -> score1=3, game_over=1, champion=01. Further valids are ignored, start is accepted and clears scores.
5. Round limit: MAX_ROUNDS=2, two draws (p1=3, p2=2) -> game_over after round 2, champion=00. Also: rst mid-COLLECT -> IDLE, all outputs 0.
6. Timeout, with CB_TIMEOUT_EN and TIMEOUT=15: only p2 submits, 15 cycles pass -> round_winner=10. With no submissions -> round_winner=00.
